dac_spi_tx: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 15 +
 rtl/dac_spi_sclk_gen.sv | 40 ++++
 rtl/dac_spi_tx.sv | 163 ++++++++++++++++
 tb/tb_dac_spi_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI transmitter.
// Pure package; no logic, no latency, no flow control.
package dac_spi_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STROBE} state_t;

    localparam int FRAME_BITS = 16;
    localparam logic [7:0] MIDSCALE = 8'h80;

    // Clocks from tick to end of the load strobe: LOAD + 32 half-periods + STROBE.
    function automatic int frame_cyc(input int sclk_div);
        return 2 + 33 * sclk_div;
    endfunction

endpackage

// File: rtl/dac_spi_sclk_gen.sv
// SCLK divider: toggles sclk every SCLK_DIV clocks while en, flags the edge it is about to make.
// Latency: first rise SCLK_DIV clocks after en; no backpressure, held low and reset when !en.
module dac_spi_sclk_gen
    import dac_spi_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          half_done;

    assign half_done  = en && (cnt == CW'(SCLK_DIV - 1));
    assign rise_pulse = half_done && !sclk;
    assign fall_pulse = half_done && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (half_done) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Paces 8-bit samples to an SPI DAC: one {CTRL,sample,0000} frame + LDAC per tick, repeating the last sample on underrun.
// Latency: buffered sample goes out on the next tick; backpressure via one-entry buffer (s_ready = !full). DAC_SPI_TX_UNDERRUN_CNT_EN adds underrun_cnt.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int         SAMPLE_DIV = 100,
    parameter int         SCLK_DIV   = 2,
    parameter logic [3:0] CTRL_BITS  = 4'b0111,
    parameter bit         DIV_CHECK  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        overrun
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    if (SCLK_DIV < 1) begin : g_bad_sclk_div
        $fatal(1, "SCLK_DIV must be at least 1");
    end
    if (DIV_CHECK && (SAMPLE_DIV <= frame_cyc(SCLK_DIV))) begin : g_bad_sample_div
        $fatal(1, "SAMPLE_DIV must exceed the frame length");
    end

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW = $clog2(SCLK_DIV + 1);

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic                  take;
    logic [7:0]            buf_dat;
    logic                  buf_vld;
    logic [7:0]            last_sample;
    logic [7:0]            next_sample;
    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic [SW-1:0]         st_cnt;
    logic                  rise_pulse;
    logic                  fall_pulse;

    assign tick        = (tick_cnt == TW'(SAMPLE_DIV - 1));
    assign take        = tick && (state == IDLE);
    assign next_sample = buf_vld ? buf_dat : last_sample;
    assign s_ready     = !buf_vld;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Take and fill are exclusive: a fill needs an empty buffer, a take needs a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_dat <= '0;
            buf_vld <= 1'b0;
        end else if (take && buf_vld) begin
            buf_vld <= 1'b0;
        end else if (s_valid && !buf_vld) begin
            buf_dat <= s_data;
            buf_vld <= 1'b1;
        end
    end

    dac_spi_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state == SHIFT),
        .sclk       (sclk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            mosi        <= 1'b0;
            cs_n        <= 1'b1;
            ldac_n      <= 1'b1;
            bit_cnt     <= '0;
            st_cnt      <= '0;
            last_sample <= MIDSCALE;
            overrun     <= 1'b0;
        end else begin
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        shift_reg   <= {CTRL_BITS, next_sample, 4'b0000};
                        mosi        <= CTRL_BITS[3];
                        cs_n        <= 1'b0;
                        last_sample <= next_sample;
                        bit_cnt     <= '0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    // Rises count bits taken by the DAC; the fall after the last one ends the frame.
                    if (rise_pulse) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (fall_pulse) begin
                        if (bit_cnt == 5'(FRAME_BITS)) begin
                            cs_n   <= 1'b1;
                            mosi   <= 1'b0;
                            st_cnt <= '0;
                            state  <= STROBE;
                        end else begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                            mosi      <= shift_reg[FRAME_BITS-2];
                        end
                    end
                end
                STROBE: begin
                    if (st_cnt == SW'(SCLK_DIV)) begin
                        ldac_n <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        ldac_n <= 1'b0;
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (take && !buf_vld && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: frame contents, timing, backpressure, underrun repeat, overrun, async reset.
module tb_dac_spi_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, sclk, mosi, cs_n, ldac_n, busy, overrun;

    logic       rst1_n = 1'b1;
    logic       s_ready1, sclk1, mosi1, cs1_n, ldac1_n, busy1, overrun1;
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt, underrun_cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dac_spi_tx #(.SAMPLE_DIV(100), .SCLK_DIV(2), .CTRL_BITS(4'b0111)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .ldac_n(ldac_n), .busy(busy), .overrun(overrun)
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    // Tick period shorter than a frame so a tick lands mid-SHIFT.
    dac_spi_tx #(.SAMPLE_DIV(60), .SCLK_DIV(2), .CTRL_BITS(4'b0111), .DIV_CHECK(1'b0)) dut_ovr (
        .clk(clk), .rst_n(rst1_n), .s_data(8'hC3), .s_valid(1'b1), .s_ready(s_ready1),
        .sclk(sclk1), .mosi(mosi1), .cs_n(cs1_n), .ldac_n(ldac1_n), .busy(busy1), .overrun(overrun1)
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame monitor: collects bits at sclk rises, cs_n low length, ldac_n low length.
    logic [15:0] fr_q[$];
    int          len_q[$];
    int          bits_q[$];
    int          stab_q[$];
    int          ld_q[$];
    logic [15:0] m_sh;
    int          m_len, m_bits, m_ld;
    bit          m_in, m_stable;
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_ldac = 1'b1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in = 1'b0; m_len = 0; m_ld = 0;
            p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; p_ldac = 1'b1;
        end else begin
            if (!cs_n) begin
                if (p_cs) begin
                    m_in = 1'b1; m_len = 0; m_bits = 0; m_sh = '0; m_stable = 1'b1;
                end
                m_len++;
                if (sclk && !p_sclk) begin
                    m_sh = {m_sh[14:0], mosi};
                    m_bits++;
                    if (mosi !== p_mosi) m_stable = 1'b0;
                end
            end else if (!p_cs && m_in) begin
                fr_q.push_back(m_sh); len_q.push_back(m_len);
                bits_q.push_back(m_bits); stab_q.push_back(int'(m_stable));
                m_in = 1'b0;
            end
            if (!ldac_n) m_ld++;
            else if (!p_ldac) begin
                ld_q.push_back(m_ld);
                m_ld = 0;
            end
            p_cs = cs_n; p_sclk = sclk; p_mosi = mosi; p_ldac = ldac_n;
        end
    end

    task automatic check_frame(input string tag, input logic [15:0] exp);
        int t = 0;
        while ((fr_q.size() == 0 || ld_q.size() == 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no frame within %0d cycles", tag, t);
        end else begin
            chk({tag, "_data"}, 32'(fr_q.pop_front()), 32'(exp));
            chk({tag, "_cs_len"}, 32'(len_q.pop_front()), 32'd65);
            chk({tag, "_bits"}, 32'(bits_q.pop_front()), 32'd16);
            chk({tag, "_mosi_stable"}, 32'(stab_q.pop_front()), 32'd1);
            chk({tag, "_ldac_len"}, 32'(ld_q.pop_front()), 32'd2);
        end
    endtask

    // Drive garbage while blocked, present the real byte once s_ready is seen.
    task automatic push(input logic [7:0] d, output int waited);
        waited  = 0;
        s_valid = 1'b1;
        s_data  = 8'hFF;
        while (!s_ready && waited < 300) begin
            @(negedge clk);
            waited++;
            s_data = waited[0] ? 8'hFF : 8'h00;
        end
        s_data = d;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    int          k, w;
    logic        prev_rdy;
    logic [15:0] f;
    int          nb, len;
    logic        ps;
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
    logic [15:0] u0;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({sclk, mosi, cs_n, ldac_n, busy, overrun, s_ready}), 32'b0011001);
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
        chk("reset_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif

        // First tick comes 100 clocks after release and sends mid-scale.
        rst_n = 1'b1;
        k = 0;
        while (cs_n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("first_tick_cycle", 32'(k), 32'd100);
        chk("busy_in_load", 32'(busy), 32'd1);
        check_frame("midscale", 16'h7800);

        push(8'hA5, w);
        chk("a5_no_wait", 32'(w), 32'd0);
        chk("a5_buffer_full", 32'(s_ready), 32'd0);
        k = 0;
        prev_rdy = s_ready;
        while (cs_n && k < 300) begin
            prev_rdy = s_ready;
            @(negedge clk);
            k++;
        end
        chk("a5_rdy_before_load", 32'(prev_rdy), 32'd0);
        chk("a5_rdy_in_load", 32'(s_ready), 32'd1);
        check_frame("a5", 16'h7A50);

        push(8'h12, w);
        chk("push12_no_wait", 32'(w), 32'd0);
        push(8'h34, w);
        chk("push34_waited", 32'(w != 0), 32'd1);
        check_frame("s12", 16'h7120);
        check_frame("s34", 16'h7340);

        push(8'h3C, w);
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
        u0 = underrun_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            check_frame($sformatf("rep3c_%0d", i), 16'h73C0);
        end
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
        chk("underrun_delta", 32'(underrun_cnt - u0), 32'd3);
`endif

        // Abort a 5A frame mid-SHIFT with 77 buffered; both must be forgotten.
        push(8'h5A, w);
        k = 0;
        while (cs_n && k < 300) begin
            @(negedge clk);
            k++;
        end
        push(8'h77, w);
        repeat (10) @(negedge clk);
        k = 0;
        while (!sclk && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_shift_sclk_high", 32'({sclk, cs_n, busy}), 32'b101);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({sclk, mosi, cs_n, ldac_n, busy, s_ready}), 32'b001101);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
`ifdef DAC_SPI_TX_UNDERRUN_CNT_EN
        chk("underrun_after_reset", 32'(underrun_cnt), 32'd0);
`endif
        check_frame("post_reset", 16'h7800);
        chk("no_overrun_main", 32'(overrun), 32'd0);

        // Overrun: tick at cycle 120 lands inside the frame started at cycle 60.
        @(negedge clk);
        rst1_n = 1'b1;
        k = 0;
        while (cs1_n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("ovr_first_tick", 32'(k), 32'd60);
        chk("ovr_clear_at_start", 32'(overrun1), 32'd0);
        f = '0; nb = 0; len = 0; ps = sclk1;
        while (!cs1_n && len < 300) begin
            len++;
            if (sclk1 && !ps) begin
                f = {f[14:0], mosi1};
                nb++;
            end
            ps = sclk1;
            @(negedge clk);
        end
        chk("ovr_frame_data", 32'(f), 32'h7C30);
        chk("ovr_frame_bits", 32'(nb), 32'd16);
        chk("ovr_cs_len", 32'(len), 32'd65);
        chk("ovr_set", 32'(overrun1), 32'd1);
        repeat (150) @(negedge clk);
        chk("ovr_sticky", 32'(overrun1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
